// File: rtl/mr18_conv_pkg.sv
// mr18_conv_pkg: constants shared by the binary-to-mixed-radix converter and
// the mixed-radix-to-binary pipeline that consumes its digits.
//   MR_M3..MR_M6 : moduli for digits A3..A6 (MR_M6 is only a range bound)
//   MR_DIV_W     : dividend width, {ext[17:0], B3, B2, B1, B0}
//   conv_state_e : converter FSM states
package mr18_conv_pkg;

  localparam int unsigned MR_M3    = 117649;
  localparam int unsigned MR_M4    = 177147;
  localparam int unsigned MR_M5    = 262027;
  localparam int unsigned MR_M6    = 262049;
  localparam int unsigned MR_DIV_W = 82;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIN  = 2'd2,
    ST_OUT  = 2'd3
  } conv_state_e;

endpackage

// File: rtl/bin_to_mr18_16_conv_if.sv
// bin_to_mr18_16_conv_if: input and output handshake bundle of the converter.
//   in side : in_valid/in_ready, sign_in, B0_in..B3_in (16b), ext_in (18b)
//   out side: out_valid/out_ready, sign_out, mr_A3_out..mr_A6_out (18b), ov_out
//   modport slave  : the converter's view
//   modport master : the producer/consumer view (drives inputs, reads digits)
interface bin_to_mr18_16_conv_if;

  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [15:0] B0_in;
  logic [15:0] B1_in;
  logic [15:0] B2_in;
  logic [15:0] B3_in;
  logic [17:0] ext_in;

  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [17:0] mr_A3_out;
  logic [17:0] mr_A4_out;
  logic [17:0] mr_A5_out;
  logic [17:0] mr_A6_out;
  logic        ov_out;

  modport slave (
    input  in_valid, sign_in, B0_in, B1_in, B2_in, B3_in, ext_in, out_ready,
    output in_ready, out_valid, sign_out, mr_A3_out, mr_A4_out, mr_A5_out,
           mr_A6_out, ov_out
  );

  modport master (
    output in_valid, sign_in, B0_in, B1_in, B2_in, B3_in, ext_in, out_ready,
    input  in_ready, out_valid, sign_out, mr_A3_out, mr_A4_out, mr_A5_out,
           mr_A6_out, ov_out
  );

endinterface

// File: rtl/mr_div_step.sv
// mr_div_step: one combinational restoring-division step.
//   r_i   : current remainder (always < divisor < 2^18)
//   bit_i : next dividend bit, MSB first
//   div_i : divisor
//   r_o   : new remainder
//   q_o   : quotient bit
module mr_div_step (
  input  logic [17:0] r_i,
  input  logic        bit_i,
  input  logic [18:0] div_i,
  output logic [17:0] r_o,
  output logic        q_o
);

  logic [18:0] r_shift;

  assign r_shift = {r_i, bit_i};
  assign q_o     = (r_shift >= div_i);
  // After a successful subtract the result is below the divisor, so it fits
  // back into 18 bits.
  assign r_o     = q_o ? 18'(r_shift - div_i) : r_shift[17:0];

endmodule

// File: rtl/bin_to_mr18_16_conv.sv
// bin_to_mr18_16_conv: iterative binary-to-mixed-radix converter.
// Divides the magnitude successively by M3, M4, M5 (MSB-first restoring
// division, one bit per cycle); the remainders are A3..A5, the final quotient
// gives A6 and the overflow flag. Sign is carried through untouched.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : in_valid/in_ready + magnitude words, out_valid/out_ready +
//                  digits, sign_out, ov_out
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// DIV   | one restoring step per cycle, DIV_W steps per digit, digits 0..2
// FIN   | capture A6 from quotient, evaluate overflow
// OUT   | out_valid=1, outputs held until out_ready
module bin_to_mr18_16_conv
  import mr18_conv_pkg::*;
#(
  parameter int unsigned M3    = MR_M3,
  parameter int unsigned M4    = MR_M4,
  parameter int unsigned M5    = MR_M5,
  parameter int unsigned M6    = MR_M6,
  parameter int unsigned DIV_W = MR_DIV_W
) (
  input logic                  clk,
  input logic                  reset_n,
  bin_to_mr18_16_conv_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DIV_W);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_FIN  = ST_FIN;
  localparam logic [1:0] S_OUT  = ST_OUT;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] x_q, x_d;
  logic [17:0]      r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [17:0]      a3_q, a3_d;
  logic [17:0]      a4_q, a4_d;
  logic [17:0]      a5_q, a5_d;
  logic [17:0]      a6_q, a6_d;
  logic             sign_q, sign_d;
  logic             ov_q, ov_d;

  logic [18:0]      divisor;
  logic [17:0]      r_step;
  logic             q_step;
  logic             last_bit;

  always_comb begin
    case (dig_q)
      2'd0:    divisor = 19'(M3);
      2'd1:    divisor = 19'(M4);
      default: divisor = 19'(M5);
    endcase
  end

  mr_div_step u_step (
    .r_i   (r_q),
    .bit_i (x_q[DIV_W-1]),
    .div_i (divisor),
    .r_o   (r_step),
    .q_o   (q_step)
  );

  assign last_bit = (cnt_q == CNT_W'(DIV_W - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    a3_d    = a3_q;
    a4_d    = a4_q;
    a5_d    = a5_q;
    a6_d    = a6_q;
    sign_d  = sign_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = DIV_W'({bus.ext_in, bus.B3_in, bus.B2_in, bus.B1_in, bus.B0_in});
          sign_d  = bus.sign_in;
          r_d     = '0;
          cnt_d   = '0;
          dig_d   = 2'd0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // The quotient bits shift in behind the dividend, so once a digit is
        // done x_q already holds the dividend for the next one.
        x_d = {x_q[DIV_W-2:0], q_step};
        if (last_bit) begin
          case (dig_q)
            2'd0:    a3_d = r_step;
            2'd1:    a4_d = r_step;
            default: a5_d = r_step;
          endcase
          r_d   = '0;
          cnt_d = '0;
          dig_d = dig_q + 2'd1;
          if (dig_q == 2'd2) state_d = S_FIN;
        end else begin
          r_d   = r_step;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        a6_d    = x_q[17:0];
        ov_d    = (x_q >= DIV_W'(M6));
        state_d = S_OUT;
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
      a3_q    <= '0;
      a4_q    <= '0;
      a5_q    <= '0;
      a6_q    <= '0;
      sign_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      a3_q    <= a3_d;
      a4_q    <= a4_d;
      a5_q    <= a5_d;
      a6_q    <= a6_d;
      sign_q  <= sign_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.sign_out  = sign_q;
  assign bus.mr_A3_out = a3_q;
  assign bus.mr_A4_out = a4_q;
  assign bus.mr_A5_out = a5_q;
  assign bus.mr_A6_out = a6_q;
  assign bus.ov_out    = ov_q;

endmodule

// File: tb/tb_bin_to_mr18_16_conv.sv
// tb_bin_to_mr18_16_conv: bench for bin_to_mr18_16_conv. Expected digits come
// from plain wide-integer modulo/divide; random values are also rebuilt from
// the observed digits and compared with the original magnitude.
module tb_bin_to_mr18_16_conv;

  localparam logic [127:0] M3 = 128'd117649;
  localparam logic [127:0] M4 = 128'd177147;
  localparam logic [127:0] M5 = 128'd262027;
  localparam logic [127:0] M6 = 128'd262049;
  localparam int LATENCY = 247;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  bin_to_mr18_16_conv_if bus ();

  bin_to_mr18_16_conv dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [17:0] last_a3, last_a4, last_a5, last_a6;
  logic        last_ov, last_sign;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_conv(input logic [81:0] v, output logic [17:0] a3,
                                   output logic [17:0] a4, output logic [17:0] a5,
                                   output logic [17:0] a6, output logic ov);
    logic [127:0] t;
    t  = {46'd0, v};
    a3 = 18'(t % M3);
    t  = t / M3;
    a4 = 18'(t % M4);
    t  = t / M4;
    a5 = 18'(t % M5);
    t  = t / M5;
    a6 = 18'(t);
    ov = (t >= M6);
  endfunction

  task automatic drive_in(input logic v, input logic s, input logic [81:0] val);
    bus.in_valid = v;
    bus.sign_in  = s;
    bus.B0_in    = val[15:0];
    bus.B1_in    = val[31:16];
    bus.B2_in    = val[47:32];
    bus.B3_in    = val[63:48];
    bus.ext_in   = val[81:64];
  endtask

  // Presents one value and returns #1 after the accepting edge.
  task automatic start_conv(input logic s, input logic [81:0] val);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check_eq("in_ready_timeout", 128'(bus.in_ready), 128'd1);
    drive_in(1'b1, s, val);
    @(posedge clk);
    #1;
    drive_in(1'b0, 1'b0, 82'd0);
  endtask

  task automatic run_conv(input string tag, input logic s, input logic [81:0] val, input int hold);
    int cyc;
    logic [17:0] e3, e4, e5, e6;
    logic eov;
    logic [127:0] recon;
    start_conv(s, val);
    check_eq({tag, "_busy"}, 128'(bus.in_ready), 128'd0);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.out_valid && cyc < 400);
    check_eq({tag, "_latency"}, 128'(cyc), 128'(LATENCY));
    ref_conv(val, e3, e4, e5, e6, eov);
    last_a3 = bus.mr_A3_out;
    last_a4 = bus.mr_A4_out;
    last_a5 = bus.mr_A5_out;
    last_a6 = bus.mr_A6_out;
    last_ov = bus.ov_out;
    last_sign = bus.sign_out;
    check_eq({tag, "_A3"}, 128'(last_a3), 128'(e3));
    check_eq({tag, "_A4"}, 128'(last_a4), 128'(e4));
    check_eq({tag, "_A5"}, 128'(last_a5), 128'(e5));
    check_eq({tag, "_A6"}, 128'(last_a6), 128'(e6));
    check_eq({tag, "_ov"}, 128'(last_ov), 128'(eov));
    check_eq({tag, "_sign"}, 128'(last_sign), 128'(s));
    if (val[81:64] == 18'd0) begin
      recon = 128'(last_a3) + M3 * (128'(last_a4) + M4 * (128'(last_a5) + M5 * 128'(last_a6)));
      check_eq({tag, "_roundtrip"}, recon, 128'(val));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      drive_in(1'b1, ~s, {$urandom, $urandom, $urandom});
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_valid"}, 128'(bus.out_valid), 128'd1);
      check_eq({tag, "_hold_ready"}, 128'(bus.in_ready), 128'd0);
      check_eq({tag, "_hold_A3"}, 128'(bus.mr_A3_out), 128'(last_a3));
      check_eq({tag, "_hold_A6"}, 128'(bus.mr_A6_out), 128'(last_a6));
      check_eq({tag, "_hold_sign"}, 128'(bus.sign_out), 128'(last_sign));
    end
    @(negedge clk);
    drive_in(1'b0, 1'b0, 82'd0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_done_valid"}, 128'(bus.out_valid), 128'd0);
    check_eq({tag, "_done_ready"}, 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 128'(bus.out_valid), 128'd0);
    check_eq({tag, "_ready"}, 128'(bus.in_ready), 128'd1);
    check_eq({tag, "_A3"}, 128'(bus.mr_A3_out), 128'd0);
    check_eq({tag, "_A4"}, 128'(bus.mr_A4_out), 128'd0);
    check_eq({tag, "_A5"}, 128'(bus.mr_A5_out), 128'd0);
    check_eq({tag, "_A6"}, 128'(bus.mr_A6_out), 128'd0);
    check_eq({tag, "_sign"}, 128'(bus.sign_out), 128'd0);
    check_eq({tag, "_ov"}, 128'(bus.ov_out), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [81:0] v;
    drive_in(1'b0, 1'b0, 82'd0);
    bus.out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    run_conv("zero", 1'b1, 82'd0, 0);
    check_eq("zero_sign_const", 128'(last_sign), 128'd1);

    run_conv("m3m1", 1'b0, 82'd117648, 0);
    check_eq("m3m1_A3_const", 128'(last_a3), 128'd117648);
    check_eq("m3m1_A4_const", 128'(last_a4), 128'd0);

    run_conv("m3", 1'b0, 82'd117649, 0);
    check_eq("m3_A3_const", 128'(last_a3), 128'd0);
    check_eq("m3_A4_const", 128'(last_a4), 128'd1);

    run_conv("m3m4", 1'b1, 82'd20841167403, 0);
    check_eq("m3m4_A4_const", 128'(last_a4), 128'd0);
    check_eq("m3m4_A5_const", 128'(last_a5), 128'd1);
    check_eq("m3m4_ov_const", 128'(last_ov), 128'd0);

    v = '1;
    run_conv("allones", 1'b0, v, 0);
    check_eq("allones_ov_const", 128'(last_ov), 128'd1);

    for (int i = 0; i < 5; i++) begin
      v = {18'd0, $urandom, $urandom};
      run_conv("rand64", 1'($urandom), v, (i == 0) ? 10 : 0);
    end

    for (int i = 0; i < 2; i++) begin
      v = {18'($urandom), $urandom, $urandom};
      run_conv("rand82", 1'($urandom), v, 0);
    end

    // Reset while A3 of the in-flight conversion is already captured.
    v = {18'd0, $urandom, $urandom};
    start_conv(1'b1, v);
    repeat (99) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;

    v = {18'd0, $urandom, $urandom};
    run_conv("postrst", 1'b1, v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
